// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin scheduler sharing one 4:1 mux/demux channel among four
// requesters. Grants one requester at a time for up to BURST beats, drives the select,
// and delivers each beat to the matching destination with a one-cycle valid strobe.
module mux_rr_sched #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BURST = 4   // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [3:0]       gnt,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] y,
    output logic             y_vld,
    output logic [WIDTH-1:0] a0,
    output logic [WIDTH-1:0] a1,
    output logic [WIDTH-1:0] a2,
    output logic [WIDTH-1:0] a3,
    output logic [3:0]       a_vld
);

    localparam logic [3:0] BurstCnt = 4'(BURST);

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       s_q, s_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_vld_q, y_vld_d;
    logic [WIDTH-1:0] a_q [4];
    logic [WIDTH-1:0] a_d [4];
    logic [3:0]       a_vld_q, a_vld_d;

    logic [WIDTH-1:0] src [4];
    logic             xfer;
    logic             drop;
    logic             burst_done;
    logic             rel;

    // Arbiter signals
    logic [3:0]       arb_req;
    logic [7:0]       arb_dbl;
    logic [3:0]       arb_rot;
    logic [1:0]       arb_off;
    logic [1:0]       arb_win;
    logic             arb_found;

    assign src[0] = i0;
    assign src[1] = i1;
    assign src[2] = i2;
    assign src[3] = i3;

    // Transfer and release conditions of the active grant.
    assign xfer       = (state_q == StGrant) && req[s_q];
    assign drop       = (state_q == StGrant) && !req[s_q];
    assign burst_done = xfer && ((cnt_q + 4'd1) == BurstCnt);
    assign rel        = drop || burst_done;

    // A requester that dropped its request is kept out of the same-edge re-arbitration.
    assign arb_req = req & ~(drop ? gnt_q : 4'b0000);

    // Rotate requests so that bit 0 is the pointer position, then pick the lowest set bit.
    assign arb_dbl   = {arb_req, arb_req};
    assign arb_rot   = arb_dbl[ptr_q +: 4];
    assign arb_found = |arb_req;
    assign arb_win   = ptr_q + arb_off;

    // Priority encode the rotated request vector.
    always_comb begin
        arb_off = 2'd3;
        if (arb_rot[0]) begin
            arb_off = 2'd0;
        end else if (arb_rot[1]) begin
            arb_off = 2'd1;
        end else if (arb_rot[2]) begin
            arb_off = 2'd2;
        end
    end

    // Next-state logic for FSM, pointer, grant and datapath registers.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        s_d     = s_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        y_vld_d = 1'b0;
        a_d     = a_q;
        a_vld_d = 4'b0000;

        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    state_d = StGrant;
                    s_d     = arb_win;
                    gnt_d   = 4'b0001 << arb_win;
                    cnt_d   = 4'd0;
                    ptr_d   = arb_win + 2'd1;
                end
            end
            StGrant: begin
                if (xfer) begin
                    y_d      = src[s_q];
                    a_d[s_q] = src[s_q];
                    y_vld_d  = 1'b1;
                    a_vld_d  = gnt_q;
                    cnt_d    = cnt_q + 4'd1;
                end
                if (rel) begin
                    if (arb_found) begin
                        // Hand over without a bubble cycle.
                        s_d   = arb_win;
                        gnt_d = 4'b0001 << arb_win;
                        cnt_d = 4'd0;
                        ptr_d = arb_win + 2'd1;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = 4'b0000;
                        cnt_d   = 4'd0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= 2'd0;
            s_q     <= 2'd0;
            gnt_q   <= 4'b0000;
            cnt_q   <= 4'd0;
            y_q     <= '0;
            y_vld_q <= 1'b0;
            a_vld_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            s_q     <= s_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            y_vld_q <= y_vld_d;
            a_vld_q <= a_vld_d;
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= a_d[i];
            end
        end
    end

    assign gnt   = gnt_q;
    assign s     = s_q;
    assign y     = y_q;
    assign y_vld = y_vld_q;
    assign a0    = a_q[0];
    assign a1    = a_q[1];
    assign a2    = a_q[2];
    assign a3    = a_q[3];
    assign a_vld = a_vld_q;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Testbench for mux_rr_sched: two instances (BURST=4 and BURST=1) share the same inputs.
// Directed scenarios check spec-derived constants; a random phase checks every output of
// both instances against a behavioural model of owner / beats-used / search pointer.
module tb_mux_rr_sched;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [3:0]   req;
    logic [W-1:0] din [4];

    logic [3:0]   d_gnt [2];
    logic [1:0]   d_s   [2];
    logic [W-1:0] d_y   [2];
    logic         d_yv  [2];
    logic [W-1:0] d_a   [2][4];
    logic [3:0]   d_av  [2];

    int checks = 0;
    int errors = 0;

    mux_rr_sched #(.WIDTH(W), .BURST(4)) u_b4 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]),
        .gnt(d_gnt[0]), .s(d_s[0]), .y(d_y[0]), .y_vld(d_yv[0]),
        .a0(d_a[0][0]), .a1(d_a[0][1]), .a2(d_a[0][2]), .a3(d_a[0][3]),
        .a_vld(d_av[0])
    );

    mux_rr_sched #(.WIDTH(W), .BURST(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .i0(din[0]), .i1(din[1]), .i2(din[2]), .i3(din[3]),
        .gnt(d_gnt[1]), .s(d_s[1]), .y(d_y[1]), .y_vld(d_yv[1]),
        .a0(d_a[1][0]), .a1(d_a[1][1]), .a2(d_a[1][2]), .a3(d_a[1][3]),
        .a_vld(d_av[1])
    );

    // Behavioural model: owner is the granted index (-1 when idle).
    int           m_owner [2] = '{-1, -1};
    int           m_beats [2] = '{0, 0};
    int           m_ptr   [2] = '{0, 0};
    int           m_s     [2] = '{0, 0};
    logic [W-1:0] m_y     [2];
    logic         m_yv    [2];
    logic [W-1:0] m_a     [2][4];
    logic [3:0]   m_av    [2];

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    task automatic grant(input int m, input int w);
        m_owner[m] = w;
        m_s[m]     = w;
        m_beats[m] = 0;
        m_ptr[m]   = (w + 1) % 4;
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            int         b;
            int         k;
            logic [3:0] cand;
            b = (m == 0) ? 4 : 1;
            if (!rst_n) begin
                m_owner[m] = -1; m_beats[m] = 0; m_ptr[m] = 0; m_s[m] = 0;
                m_y[m] = '0; m_yv[m] = 1'b0; m_av[m] = 4'b0;
                for (int j = 0; j < 4; j++) m_a[m][j] = '0;
            end else begin
                m_yv[m] = 1'b0;
                m_av[m] = 4'b0;
                if (m_owner[m] < 0) begin
                    if (req != 4'b0) grant(m, pick(req, m_ptr[m]));
                end else begin
                    k    = m_owner[m];
                    cand = req;
                    if (req[k]) begin
                        m_y[m]    = din[k];
                        m_a[m][k] = din[k];
                        m_yv[m]   = 1'b1;
                        m_av[m]   = 4'(1 << k);
                        m_beats[m]++;
                    end else begin
                        cand[k] = 1'b0;
                    end
                    if (!req[k] || m_beats[m] == b) begin
                        if (cand != 4'b0) grant(m, pick(cand, m_ptr[m]));
                        else m_owner[m] = -1;
                    end
                end
            end
        end
    endtask

    // Advance one clock: DUT and model both sample at the rising edge, outputs read at fall.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'hF;
        for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
        tick();
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++; if (d_gnt[m] !== 4'b0) begin errors++; $display("FAIL reset_gnt[%0d] got %b want 0000", m, d_gnt[m]); end
            checks++; if (d_s[m] !== 2'd0) begin errors++; $display("FAIL reset_s[%0d] got %0d want 0", m, d_s[m]); end
            checks++; if (d_y[m] !== '0 || d_yv[m] !== 1'b0) begin errors++; $display("FAIL reset_y[%0d] got %h/%b want 00/0", m, d_y[m], d_yv[m]); end
            checks++; if (d_av[m] !== 4'b0) begin errors++; $display("FAIL reset_avld[%0d] got %b want 0000", m, d_av[m]); end
            for (int j = 0; j < 4; j++) begin
                checks++; if (d_a[m][j] !== '0) begin errors++; $display("FAIL reset_a%0d[%0d] got %h want 00", j, m, d_a[m][j]); end
            end
        end
        rst_n = 1'b1;
        tick();
        checks++; if (d_gnt[0] !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt got %b want 0001", d_gnt[0]); end
        checks++; if (d_yv[0] !== 1'b0) begin errors++; $display("FAIL reset_first_yvld got %b want 0", d_yv[0]); end
    endtask

    task automatic test_single();
        do_reset();
        req    = 4'b0001;
        din[0] = 8'd10;
        for (int i = 1; i < 4; i++) din[i] = 8'($urandom);
        tick();
        checks++; if (d_gnt[0] !== 4'b0001) begin errors++; $display("FAIL single_grant got %b want 0001", d_gnt[0]); end
        for (int j = 0; j < 8; j++) begin
            tick();
            checks++; if (d_gnt[0] !== 4'b0001) begin errors++; $display("FAIL single_gnt beat %0d got %b want 0001", j, d_gnt[0]); end
            checks++; if (d_a[0][0] !== 8'd10 || d_y[0] !== 8'd10) begin errors++; $display("FAIL single_data beat %0d got a0=%0d y=%0d want 10", j, d_a[0][0], d_y[0]); end
            checks++; if (d_av[0] !== 4'b0001) begin errors++; $display("FAIL single_avld beat %0d got %b want 0001", j, d_av[0]); end
            checks++; if ({d_a[0][1], d_a[0][2], d_a[0][3]} !== '0) begin errors++; $display("FAIL single_others beat %0d got %h %h %h want 0", j, d_a[0][1], d_a[0][2], d_a[0][3]); end
        end
    endtask

    task automatic test_contention();
        logic [W-1:0] vals [4];
        int           own;
        vals = '{8'd10, 8'd12, 8'd15, 8'd8};
        do_reset();
        req = 4'hF;
        for (int i = 0; i < 4; i++) din[i] = vals[i];
        tick();
        for (int j = 0; j < 20; j++) begin
            tick();
            own = (j / 4) % 4;
            checks++; if (d_y[0] !== vals[own] || d_yv[0] !== 1'b1) begin errors++; $display("FAIL contention_y beat %0d got %0d/%b want %0d/1", j, d_y[0], d_yv[0], vals[own]); end
            checks++; if (d_av[0] !== 4'(1 << own)) begin errors++; $display("FAIL contention_avld beat %0d got %b want %b", j, d_av[0], 4'(1 << own)); end
            checks++; if (d_s[0] !== 2'(((j + 1) / 4) % 4)) begin errors++; $display("FAIL contention_s beat %0d got %0d want %0d", j, d_s[0], ((j + 1) / 4) % 4); end
        end
    endtask

    task automatic test_early_drop();
        do_reset();
        req    = 4'b1100;
        din[2] = 8'd14;
        din[3] = 8'd33;
        tick();
        checks++; if (d_gnt[0] !== 4'b0100) begin errors++; $display("FAIL drop_grant got %b want 0100", d_gnt[0]); end
        for (int j = 0; j < 2; j++) begin
            tick();
            checks++; if (d_a[0][2] !== 8'd14 || d_av[0] !== 4'b0100) begin errors++; $display("FAIL drop_beat %0d got a2=%0d avld=%b want 14/0100", j, d_a[0][2], d_av[0]); end
        end
        req = 4'b1000;
        tick();
        checks++; if (d_av[0] !== 4'b0 || d_yv[0] !== 1'b0) begin errors++; $display("FAIL drop_nostrobe got %b/%b want 0000/0", d_av[0], d_yv[0]); end
        checks++; if (d_gnt[0] !== 4'b1000) begin errors++; $display("FAIL drop_handover got %b want 1000", d_gnt[0]); end
        checks++; if (d_a[0][2] !== 8'd14) begin errors++; $display("FAIL drop_hold got %0d want 14", d_a[0][2]); end
    endtask

    // Continues from test_early_drop with index 3 freshly granted.
    task automatic test_fairness();
        tick();
        tick();
        tick();
        req = 4'b1001;
        tick();
        checks++; if (d_av[0] !== 4'b1000 || d_a[0][3] !== 8'd33) begin errors++; $display("FAIL fair_last_beat got %b/%0d want 1000/33", d_av[0], d_a[0][3]); end
        checks++; if (d_gnt[0] !== 4'b0001 || d_s[0] !== 2'd0) begin errors++; $display("FAIL fair_grant got %b/%0d want 0001/0", d_gnt[0], d_s[0]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req    = 4'b0001;
        din[0] = 8'd77;
        tick();
        tick();
        checks++; if (d_av[0] !== 4'b0001) begin errors++; $display("FAIL mid_beat1 got %b want 0001", d_av[0]); end
        rst_n = 1'b0;
        tick();
        checks++; if (d_yv[0] !== 1'b0 || d_av[0] !== 4'b0) begin errors++; $display("FAIL mid_strobe got %b/%b want 0/0000", d_yv[0], d_av[0]); end
        checks++; if (d_gnt[0] !== 4'b0 || d_s[0] !== 2'd0) begin errors++; $display("FAIL mid_gnt got %b/%0d want 0000/0", d_gnt[0], d_s[0]); end
        checks++; if (d_a[0][0] !== '0 || d_y[0] !== '0) begin errors++; $display("FAIL mid_data got %h/%h want 00/00", d_a[0][0], d_y[0]); end
        rst_n = 1'b1;
        req   = 4'b1001;
        tick();
        checks++; if (d_gnt[0] !== 4'b0001) begin errors++; $display("FAIL mid_ptr got %b want 0001", d_gnt[0]); end
    endtask

    task automatic test_burst1();
        int own;
        int nxt;
        do_reset();
        req = 4'b0110;
        tick();
        checks++; if (d_gnt[1] !== 4'b0010) begin errors++; $display("FAIL b1_grant got %b want 0010", d_gnt[1]); end
        for (int j = 0; j < 6; j++) begin
            tick();
            own = (j % 2 == 0) ? 1 : 2;
            nxt = (j % 2 == 0) ? 2 : 1;
            checks++; if (d_av[1] !== 4'(1 << own) || d_yv[1] !== 1'b1) begin errors++; $display("FAIL b1_avld beat %0d got %b want %b", j, d_av[1], 4'(1 << own)); end
            checks++; if (d_gnt[1] !== 4'(1 << nxt)) begin errors++; $display("FAIL b1_gnt beat %0d got %b want %b", j, d_gnt[1], 4'(1 << nxt)); end
        end
    endtask

    task automatic test_random();
        logic [3:0] eg;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req = ($urandom_range(0, 9) < 2) ? 4'b0 : 4'($urandom);
            for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
            rst_n = ($urandom_range(0, 59) != 0);
            tick();
            for (int m = 0; m < 2; m++) begin
                eg = (m_owner[m] < 0) ? 4'b0 : 4'(1 << m_owner[m]);
                checks++; if (d_gnt[m] !== eg) begin errors++; $display("FAIL rnd_gnt[%0d] cyc %0d got %b want %b", m, c, d_gnt[m], eg); end
                checks++; if (d_s[m] !== 2'(m_s[m])) begin errors++; $display("FAIL rnd_s[%0d] cyc %0d got %0d want %0d", m, c, d_s[m], m_s[m]); end
                checks++; if (d_y[m] !== m_y[m] || d_yv[m] !== m_yv[m]) begin errors++; $display("FAIL rnd_y[%0d] cyc %0d got %h/%b want %h/%b", m, c, d_y[m], d_yv[m], m_y[m], m_yv[m]); end
                checks++; if (d_av[m] !== m_av[m]) begin errors++; $display("FAIL rnd_avld[%0d] cyc %0d got %b want %b", m, c, d_av[m], m_av[m]); end
                for (int j = 0; j < 4; j++) begin
                    checks++; if (d_a[m][j] !== m_a[m][j]) begin errors++; $display("FAIL rnd_a%0d[%0d] cyc %0d got %h want %h", j, m, c, d_a[m][j], m_a[m][j]); end
                end
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0;
        for (int i = 0; i < 4; i++) din[i] = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_early_drop();
        test_fairness();
        test_reset_mid();
        test_burst1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
